first_nios2_system_sysid_checker: RTL and testbench

Boot-time integrity checker that sits directly downstream of the system ID peripheral on the Avalon-MM fabric. It acts as a small Avalon-MM read master: it reads the ID word (address 0) and the build timestamp word (address 1), compares both against build-time expected values, and reports pass, fail or timeout to the reset/boot logic and a status LED. It runs automatically after reset and can be re-triggered by a start pulse.

---
 rtl/first_nios2_system_sysid_checker.sv | 206 ++++++++++++++++++++
 tb/tb_first_nios2_system_sysid_checker.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/first_nios2_system_sysid_checker.sv
// ============================================================================
// first_nios2_system_sysid_checker
//
// Boot-time integrity checker for the system ID peripheral. Acts as a tiny
// Avalon-MM read master: reads the ID word (address 0) and the build
// timestamp word (address 1), compares both against build-time constants and
// reports pass / fail / timeout to the boot logic and a status LED. A check
// runs automatically after reset (AUTO_START=1) and can be re-run with start.
//
// Ports:
//   clock          in   system clock, rising edge
//   reset_n        in   synchronous active-low reset
//   start          in   one-cycle request to run a check (ignored while busy)
//   m_address      out  word address to the sysid slave (0 = ID, 1 = stamp)
//   m_read         out  Avalon read strobe
//   m_readdata     in   read data, valid when m_read=1 and m_waitrequest=0
//   m_waitrequest  in   slave stall
//   busy           out  check in progress
//   done           out  result outputs valid while high
//   pass           out  both words matched
//   id_mismatch    out  ID word differed from EXPECTED_ID
//   ts_mismatch    out  timestamp word differed from EXPECTED_TIMESTAMP
//   timeout        out  a read stalled for TIMEOUT_CYCLES cycles
//   id_value       out  captured ID word
//   ts_value       out  captured timestamp word
// ============================================================================
module first_nios2_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1363792568,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        m_address,
    output logic        m_read,
    input  logic [31:0] m_readdata,
    input  logic        m_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    // A zero TIMEOUT_CYCLES disables the timeout; the counter then still
    // needs at least one bit so the declaration stays legal.
    localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam bit TIMEOUT_ENABLED = (TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        RD_TS,
        CHECK,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              auto_pending;
    logic [CNT_W-1:0]  wait_cnt;
    logic              in_read;
    logic              timeout_hit;

    // The read states are the only ones where the bus is active and where the
    // stall counter matters. A timeout fires on the last permitted stall
    // cycle, so m_read is high for exactly TIMEOUT_CYCLES stalled cycles.
    always_comb begin
        in_read     = (state == RD_ID) || (state == RD_TS);
        timeout_hit = TIMEOUT_ENABLED && in_read && m_waitrequest && (wait_cnt == CNT_LAST);
    end

    // Next-state logic. auto_pending is only high during the first cycle
    // after reset, which is what launches the automatic boot check. A start
    // pulse outside IDLE/DONE is simply dropped, never queued.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if ((AUTO_START && auto_pending) || start) begin
                    state_next = RD_ID;
                end
            end
            RD_ID: begin
                if (timeout_hit) begin
                    state_next = DONE;
                end else if (!m_waitrequest) begin
                    state_next = RD_TS;
                end
            end
            RD_TS: begin
                if (timeout_hit) begin
                    state_next = DONE;
                end else if (!m_waitrequest) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                state_next = DONE;
            end
            DONE: begin
                if (start) begin
                    state_next = RD_ID;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register plus the one-shot "just left reset" marker.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= IDLE;
            auto_pending <= 1'b1;
        end else begin
            state        <= state_next;
            auto_pending <= 1'b0;
        end
    end

    // Stall counter: restarts whenever a new state is entered and counts the
    // stalled cycles of the current read. It saturates rather than wrapping,
    // which only matters when the timeout is disabled.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (state_next != state) begin
            wait_cnt <= '0;
        end else if (in_read && m_waitrequest && (wait_cnt != CNT_MAX)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Data capture and result flags. Words are captured on the accepting
    // cycle of each read, compared in CHECK, and held in DONE until a new
    // start clears the flags. A timeout forces a clean fail with no
    // mismatch flags so boot logic can tell the two failure kinds apart.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            id_value    <= '0;
            ts_value    <= '0;
            pass        <= 1'b0;
            id_mismatch <= 1'b0;
            ts_mismatch <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            case (state)
                RD_ID: begin
                    if (timeout_hit) begin
                        timeout     <= 1'b1;
                        pass        <= 1'b0;
                        id_mismatch <= 1'b0;
                        ts_mismatch <= 1'b0;
                    end else if (!m_waitrequest) begin
                        id_value <= m_readdata;
                    end
                end
                RD_TS: begin
                    if (timeout_hit) begin
                        timeout     <= 1'b1;
                        pass        <= 1'b0;
                        id_mismatch <= 1'b0;
                        ts_mismatch <= 1'b0;
                    end else if (!m_waitrequest) begin
                        ts_value <= m_readdata;
                    end
                end
                CHECK: begin
                    id_mismatch <= (id_value != EXPECTED_ID);
                    ts_mismatch <= (ts_value != EXPECTED_TIMESTAMP);
                    pass        <= (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TIMESTAMP);
                    timeout     <= 1'b0;
                end
                DONE: begin
                    if (start) begin
                        pass        <= 1'b0;
                        id_mismatch <= 1'b0;
                        ts_mismatch <= 1'b0;
                        timeout     <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Bus and status outputs decode purely from the registered state, so the
    // address and strobe cannot move while the slave is stalling us.
    always_comb begin
        m_read    = in_read;
        m_address = (state == RD_TS);
        busy      = in_read || (state == CHECK);
        done      = (state == DONE);
    end

endmodule

// File: tb/tb_first_nios2_system_sysid_checker.sv
// ============================================================================
// tb_first_nios2_system_sysid_checker
//
// Self-checking bench for the sysid checker. A simple Avalon slave model
// serves the ID / timestamp words with a programmable number of wait states.
// The expected bus activity of every cycle and the final result are derived
// from the check's rules with plain arithmetic.
// ============================================================================
module tb_first_nios2_system_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1363792568;
    localparam int          TO     = 8;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        m_address;
    logic        m_read;
    logic [31:0] m_readdata;
    logic        m_waitrequest;
    logic        busy;
    logic        done;
    logic        pass;
    logic        id_mismatch;
    logic        ts_mismatch;
    logic        timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;

    int          vectors     = 0;
    int          miscompares = 0;

    int          id_wait_left = 0;
    int          ts_wait_left = 0;
    logic [31:0] slave_id_word = '0;
    logic [31:0] slave_ts_word = '0;
    logic [31:0] model_id_value = '0;
    logic [31:0] model_ts_value = '0;

    first_nios2_system_sysid_checker #(
        .EXPECTED_ID        (EXP_ID),
        .EXPECTED_TIMESTAMP (EXP_TS),
        .TIMEOUT_CYCLES     (TO),
        .AUTO_START         (1'b1)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .m_address     (m_address),
        .m_read        (m_read),
        .m_readdata    (m_readdata),
        .m_waitrequest (m_waitrequest),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .id_mismatch   (id_mismatch),
        .ts_mismatch   (ts_mismatch),
        .timeout       (timeout),
        .id_value      (id_value),
        .ts_value      (ts_value)
    );

    // 100 MHz free-running clock.
    always #5 clock = ~clock;

    // One comparison: counts it and reports a failure with tag and values.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Slave model: stalls the requested number of cycles per read, then
    // returns the programmed word. Outside a read it drives noise, which the
    // checker must ignore.
    task automatic slaveRespond();
        if (m_read === 1'b1 && m_address === 1'b0) begin
            if (id_wait_left > 0) begin
                m_waitrequest = 1'b1;
                m_readdata    = $urandom;
                id_wait_left--;
            end else begin
                m_waitrequest = 1'b0;
                m_readdata    = slave_id_word;
            end
        end else if (m_read === 1'b1 && m_address === 1'b1) begin
            if (ts_wait_left > 0) begin
                m_waitrequest = 1'b1;
                m_readdata    = $urandom;
                ts_wait_left--;
            end else begin
                m_waitrequest = 1'b0;
                m_readdata    = slave_ts_word;
            end
        end else begin
            m_waitrequest = 1'($urandom_range(0, 1));
            m_readdata    = $urandom;
        end
    endtask

    // Advance one clock and sample away from the edge.
    task automatic tick();
        @(posedge clock);
        #1;
        slaveRespond();
    endtask

    // Cycle (counted from the first cycle after the launching edge) at which
    // done is first expected high.
    function automatic int doneCycle(input int w1, input int w2);
        int a;
        if (w1 >= TO) return TO + 1;
        a = w1 + 1;
        if (w2 >= TO) return a + TO + 1;
        return a + w2 + 1 + 2;
    endfunction

    // Expected {m_read, m_address, busy, done} in cycle k of a check.
    function automatic logic [3:0] expectedBus(input int k, input int w1, input int w2);
        if (k >= doneCycle(w1, w2)) return 4'b0001;
        if (w1 >= TO || k <= w1 + 1) return 4'b1010;
        if (w2 >= TO || k <= w1 + w2 + 2) return 4'b1110;
        return 4'b0010;
    endfunction

    // Runs one complete check and checks every cycle plus the final result.
    // extra_start_at (1..n-1) injects a start pulse while busy; 0 = none.
    task automatic applyStimulus(input string name, input logic [31:0] id_word, input logic [31:0] ts_word,
                                 input int w1, input int w2, input bit use_start, input int extra_start_at);
        int   n;
        bit   timed_out;
        logic [3:0] exp_flags;
        slave_id_word = id_word;
        slave_ts_word = ts_word;
        id_wait_left  = w1;
        ts_wait_left  = w2;
        n = doneCycle(w1, w2);
        start = use_start;
        for (int k = 1; k <= n; k++) begin
            tick();
            start = (k == extra_start_at);
            checkOutput($sformatf("%s_bus_c%0d", name, k), {28'd0, m_read, m_address, busy, done},
                        {28'd0, expectedBus(k, w1, w2)});
        end
        start = 1'b0;
        timed_out = (w1 >= TO) || (w2 >= TO);
        if (w1 < TO) model_id_value = id_word;
        if (!timed_out) model_ts_value = ts_word;
        exp_flags = {!timed_out && id_word == EXP_ID && ts_word == EXP_TS,
                     !timed_out && id_word != EXP_ID,
                     !timed_out && ts_word != EXP_TS,
                     timed_out};
        checkOutput({name, "_flags"}, {28'd0, pass, id_mismatch, ts_mismatch, timeout}, {28'd0, exp_flags});
        checkOutput({name, "_id_value"}, id_value, model_id_value);
        checkOutput({name, "_ts_value"}, ts_value, model_ts_value);
        for (int h = 0; h < 2; h++) begin
            tick();
            checkOutput($sformatf("%s_hold%0d", name, h),
                        {24'd0, m_read, m_address, busy, done, pass, id_mismatch, ts_mismatch, timeout},
                        {24'd0, 4'b0001, exp_flags});
        end
    endtask

    // Everything the checker drives must be zero right after a reset edge.
    task automatic checkResetState(input string name);
        checkOutput({name, "_ctl"}, {24'd0, m_read, m_address, busy, done, pass, id_mismatch, ts_mismatch, timeout}, 32'd0);
        checkOutput({name, "_id_value"}, id_value, 32'd0);
        checkOutput({name, "_ts_value"}, ts_value, 32'd0);
        model_id_value = '0;
        model_ts_value = '0;
    endtask

    // Directed scenarios first, then randomized checks against the model.
    initial begin
        logic [31:0] rid;
        logic [31:0] rts;
        int          rw1;
        int          rw2;
        int          rn;
        int          rextra;

        reset_n = 1'b0;
        start   = 1'b0;
        m_waitrequest = 1'b0;
        m_readdata    = '0;
        $display("[TB] start of sysid checker bench");
        repeat (3) tick();
        checkResetState("reset");
        reset_n = 1'b1;

        applyStimulus("auto_pass", EXP_ID, EXP_TS, 0, 0, 1'b0, 0);
        applyStimulus("bad_ts", EXP_ID, 32'h51498EB9, 0, 0, 1'b1, 0);
        applyStimulus("waits_3_2", EXP_ID, EXP_TS, 3, 2, 1'b1, 0);
        applyStimulus("timeout_id", 32'hDEADBEEF, EXP_TS, 1000, 0, 1'b1, 0);
        applyStimulus("busy_start", EXP_ID, EXP_TS, 0, 0, 1'b1, 2);
        applyStimulus("restart", 32'h00000001, EXP_TS, 0, 0, 1'b1, 0);
        applyStimulus("timeout_ts", 32'h12345678, EXP_TS, 1, 1000, 1'b1, 0);

        // Reset in the middle of the timestamp read, then auto-restart.
        slave_id_word = EXP_ID;
        slave_ts_word = EXP_TS;
        id_wait_left  = 0;
        ts_wait_left  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checkOutput("midreset_in_rd_ts", {28'd0, m_read, m_address, busy, done}, {28'd0, 4'b1110});
        reset_n = 1'b0;
        tick();
        checkResetState("midreset");
        reset_n = 1'b1;
        applyStimulus("midreset_auto", EXP_ID, EXP_TS, 0, 0, 1'b0, 0);

        for (int r = 0; r < 24; r++) begin
            rid = ($urandom_range(0, 1) != 0) ? EXP_ID : 32'($urandom);
            rts = ($urandom_range(0, 1) != 0) ? EXP_TS : 32'($urandom);
            rw1 = $urandom_range(0, 9);
            rw2 = $urandom_range(0, 9);
            rn  = doneCycle(rw1, rw2);
            rextra = ($urandom_range(0, 2) == 0) ? $urandom_range(1, rn - 1) : 0;
            applyStimulus($sformatf("rnd%0d", r), rid, rts, rw1, rw2, 1'b1, rextra);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
